// File: rtl/vidgen_dpi.sv
// DPI timing generator with 2-bit VRAM fetch and 4-entry palette lookup.
// Output is a two-stage pipeline behind the raster counters, so the palette lookup lines up with the synchronous VRAM read.
module vidgen_dpi #(
  parameter int unsigned H_ACTIVE = 160,
  parameter int unsigned H_FP     = 8,
  parameter int unsigned H_SYNC   = 4,
  parameter int unsigned H_BP     = 8,
  parameter int unsigned V_ACTIVE = 144,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 6
) (
  input  logic        rgb_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] palette,
  output logic [15:0] vram_addr,
  output logic        vram_re,
  input  logic [1:0]  vram_rdata,
  output logic        rgb_de,
  output logic        rgb_hsync,
  output logic        rgb_vsync,
  output logic [3:0]  rgb_data,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_total_check
    $error("vidgen_dpi: H_TOTAL/V_TOTAL must not exceed 1023");
  end
  if (H_ACTIVE < 1 || H_ACTIVE > 256 || V_ACTIVE < 1 || V_ACTIVE > 256) begin : g_active_check
    $error("vidgen_dpi: H_ACTIVE/V_ACTIVE must be in 1..256");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_sync_check
    $error("vidgen_dpi: sync widths must be at least 1");
  end

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_HSB_C  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_HSE_C  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_VSB_C  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_VSE_C  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  logic       active, hs, vs;

  logic       de1_q, hs1_q, vs1_q, fs1_q;
  logic       de1_d, hs1_d, vs1_d, fs1_d;

  logic       de2_q, hs2_q, vs2_q, fs2_q;
  logic       de2_d, hs2_d, vs2_d, fs2_d;
  logic [3:0] data2_q, data2_d;
  logic [3:0] pix_color;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!enable) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == H_LAST_C) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST_C) ? '0 : vcnt_q + 10'd1;
    end else begin
      hcnt_d = hcnt_q + 10'd1;
    end
  end

  always_comb begin
    active    = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    hs        = (hcnt_q >= H_HSB_C) && (hcnt_q < H_HSE_C);
    vs        = (vcnt_q >= V_VSB_C) && (vcnt_q < V_VSE_C);
    vram_re   = active & enable;
    vram_addr = {vcnt_q[7:0], hcnt_q[7:0]};
  end

  // Stage loads are gated by enable so a disable blanks everything on one edge
  // and no in-flight pixel survives into the restarted frame.
  always_comb begin
    de1_d = active & enable;
    hs1_d = hs & enable;
    vs1_d = vs & enable;
    fs1_d = (hcnt_q == '0) && (vcnt_q == '0) && enable;
  end

  always_comb begin
    pix_color = '0;
    case (vram_rdata)
      2'd0:    pix_color = palette[3:0];
      2'd1:    pix_color = palette[7:4];
      2'd2:    pix_color = palette[11:8];
      default: pix_color = palette[15:12];
    endcase
  end

  always_comb begin
    de2_d   = de1_q & enable;
    hs2_d   = hs1_q & enable;
    vs2_d   = vs1_q & enable;
    fs2_d   = fs1_q & enable;
    data2_d = (enable && de1_q) ? pix_color : '0;
  end

  always_ff @(posedge rgb_clk or posedge rst) begin
    if (rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      de2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      fs2_q   <= 1'b0;
      data2_q <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      de1_q   <= de1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= fs1_d;
      de2_q   <= de2_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      fs2_q   <= fs2_d;
      data2_q <= data2_d;
    end
  end

  always_comb begin
    rgb_de      = de2_q;
    rgb_hsync   = hs2_q;
    rgb_vsync   = vs2_q;
    rgb_data    = data2_q;
    frame_start = fs2_q;
  end

endmodule

// File: tb/tb_vidgen_dpi.sv
// Directed bench for vidgen_dpi: a table of output checkpoints across one full frame
// plus hand-written sequences for idle, enable drop/restart, palette change and async reset.
module tb_vidgen_dpi;

  logic        rgb_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] palette;
  logic [15:0] vram_addr;
  logic        vram_re;
  logic [1:0]  vram_rdata;
  logic        rgb_de, rgb_hsync, rgb_vsync, frame_start;
  logic [3:0]  rgb_data;

  int n_tests = 0;
  int n_fail  = 0;

  vidgen_dpi #(
    .H_ACTIVE(160), .H_FP(8), .H_SYNC(4), .H_BP(8),
    .V_ACTIVE(144), .V_FP(2), .V_SYNC(2), .V_BP(6)
  ) dut (
    .rgb_clk    (rgb_clk),
    .rst        (rst),
    .enable     (enable),
    .palette    (palette),
    .vram_addr  (vram_addr),
    .vram_re    (vram_re),
    .vram_rdata (vram_rdata),
    .rgb_de     (rgb_de),
    .rgb_hsync  (rgb_hsync),
    .rgb_vsync  (rgb_vsync),
    .rgb_data   (rgb_data),
    .frame_start(frame_start)
  );

  always #5 rgb_clk = ~rgb_clk;

  // RAM model: pixel value is x[1:0], returned one clock after the address.
  always @(posedge rgb_clk) vram_rdata <= vram_addr[1:0];

  // Packed as {de, hsync, vsync, frame_start, data[3:0]}.
  function automatic logic [7:0] outs();
    return {rgb_de, rgb_hsync, rgb_vsync, frame_start, rgb_data};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned t;
    logic [15:0] pal;
    logic [7:0]  exp_outs;
    logic        chk_addr;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  int unsigned t;
  int          fs_extra;

  initial begin
    // t counts clocks since the first frame_start output; counters lead outputs by 2.
    vecs.push_back('{0,     16'hF850, 8'h90, 1'b1, 16'h0002});
    vecs.push_back('{1,     16'hF850, 8'h85, 1'b0, 16'h0000});
    vecs.push_back('{2,     16'hF850, 8'h88, 1'b0, 16'h0000});
    vecs.push_back('{3,     16'hF850, 8'h8F, 1'b0, 16'h0000});
    vecs.push_back('{159,   16'hF850, 8'h8F, 1'b0, 16'h0000});
    vecs.push_back('{160,   16'hF850, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{167,   16'hF850, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{168,   16'hF850, 8'h40, 1'b0, 16'h0000});
    vecs.push_back('{171,   16'hF850, 8'h40, 1'b0, 16'h0000});
    vecs.push_back('{172,   16'hF850, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{178,   16'hF850, 8'h00, 1'b1, 16'h0100});
    vecs.push_back('{180,   16'hF850, 8'h80, 1'b0, 16'h0000});
    vecs.push_back('{181,   16'hF850, 8'h85, 1'b0, 16'h0000});
    vecs.push_back('{25899, 16'hF850, 8'h8F, 1'b0, 16'h0000});
    vecs.push_back('{25920, 16'hF850, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{26279, 16'hF850, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{26280, 16'hF850, 8'h20, 1'b0, 16'h0000});
    vecs.push_back('{26448, 16'hF850, 8'h60, 1'b0, 16'h0000});
    vecs.push_back('{26639, 16'hF850, 8'h20, 1'b0, 16'h0000});
    vecs.push_back('{26640, 16'hF850, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{27718, 16'hF850, 8'h00, 1'b1, 16'h0000});
    vecs.push_back('{27720, 16'hF850, 8'h90, 1'b0, 16'h0000});

    rst     = 1'b1;
    enable  = 1'b0;
    palette = 16'hF850;
    repeat (3) @(negedge rgb_clk);
    rst = 1'b0;

    // Idle: everything held at zero.
    for (int i = 0; i < 100; i++) begin
      @(negedge rgb_clk);
      check("idle", {7'd0, outs(), vram_addr, vram_re}, 32'd0);
    end

    // Enable rises before edge E0; frame_start appears after E1.
    enable = 1'b1;
    #1 check("start_addr", {15'd0, vram_addr, vram_re}, {15'd0, 16'h0000, 1'b1});
    @(negedge rgb_clk);
    check("start_e0", {24'd0, outs()}, 32'd0);
    @(negedge rgb_clk);
    t = 0;
    fs_extra = 0;

    foreach (vecs[k]) begin
      palette = vecs[k].pal;
      while (t < vecs[k].t) begin
        @(negedge rgb_clk);
        t++;
        if (frame_start && t != 27720) fs_extra++;
      end
      check($sformatf("vec_t%0d", vecs[k].t), {24'd0, outs()}, {24'd0, vecs[k].exp_outs});
      if (vecs[k].chk_addr)
        check($sformatf("addr_t%0d", vecs[k].t), {16'd0, vram_addr}, {16'd0, vecs[k].exp_addr});
    end
    check("fs_period", fs_extra, 0);

    // Drop enable when counters sit at hcnt=50, vcnt=3.
    while (t < 27720 + 588) begin
      @(negedge rgb_clk);
      t++;
    end
    check("pre_drop_addr", {16'd0, vram_addr}, {16'd0, 16'h0332});
    enable = 1'b0;
    @(negedge rgb_clk);
    check("drop_outs", {7'd0, outs(), vram_addr, vram_re}, 32'd0);
    repeat (4) @(negedge rgb_clk);
    check("drop_hold", {24'd0, outs()}, 32'd0);

    enable = 1'b1;
    #1 check("reen_addr", {15'd0, vram_addr, vram_re}, {15'd0, 16'h0000, 1'b1});
    @(negedge rgb_clk);
    check("reen_e0", {24'd0, outs()}, 32'd0);
    @(negedge rgb_clk);
    check("reen_fs", {24'd0, outs()}, 32'h90);
    t = 0;

    // Palette change while counter hcnt=80, pixel 78 on the output.
    while (t < 78) begin
      @(negedge rgb_clk);
      t++;
    end
    check("pal_before", {24'd0, outs()}, 32'h88);
    palette = 16'h0000;
    while (t < 159) begin
      @(negedge rgb_clk);
      t++;
      check($sformatf("pal_after_%0d", t), {24'd0, outs()}, 32'h80);
    end
    @(negedge rgb_clk);
    t++;
    check("pal_line_end", {24'd0, outs()}, 32'h00);
    palette = 16'hF850;

    // Asynchronous reset mid-line.
    while (t < 181) begin
      @(negedge rgb_clk);
      t++;
    end
    check("pre_rst", {24'd0, outs()}, 32'h85);
    #2 rst = 1'b1;
    #1 check("async_rst", {8'd0, outs(), vram_addr}, 32'd0);
    @(negedge rgb_clk);
    rst    = 1'b0;
    enable = 1'b0;
    @(negedge rgb_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vidgen_dpi.md
# vidgen_dpi

Video generator for the DPI output path: produces DPI timing (rgb_de, rgb_hsync, rgb_vsync) in the rgb_clk domain and reads 2-bit pixels from the frame VRAM. It maps each pixel through a 4-entry, 4-bit palette onto rgb_data. The VRAM read port is synchronous to rgb_clk, uses {y[7:0], x[7:0]} addressing (the same layout the video sampler writes), and has 1-cycle read latency.

## Interface
- H_ACTIVE, 160, active pixels per line (1..256)
- H_FP, 8, horizontal front porch, clocks
- H_SYNC, 4, hsync width, clocks (>=1)
- H_BP, 8, horizontal back porch, clocks
- V_ACTIVE, 144, active lines per frame (1..256)
- V_FP, 2, vertical front porch, lines
- V_SYNC, 2, vsync width, lines (>=1)
- V_BP, 6, vertical back porch, lines
- rgb_clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run generator; low = hold counters at 0, blank outputs
- palette  in  16  entry n at bits [4n+3:4n]; sampled combinationally at output stage
- vram_addr  out  16  {vcnt[7:0], hcnt[7:0]}; combinational from counters
- vram_re  out  1  read strobe, high for active positions while enable=1
- vram_rdata  in  2  pixel data, valid one clock after vram_addr/vram_re
- rgb_de  out  1  data enable, active-high
- rgb_hsync  out  1  hsync, active-high
- rgb_vsync  out  1  vsync, active-high
- rgb_data  out  4  pixel value; 0 whenever rgb_de=0
- frame_start  out  1  one-clock pulse coincident with output of pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Counters hcnt, vcnt are 10 bits wide each; elaboration fails if a total exceeds 1023.
- Counters advance only on edges where enable=1. hcnt increments 0..H_TOTAL-1 and wraps to 0. On wrap, vcnt increments 0..V_TOTAL-1 and wraps to 0 at the end of the frame.
- Stage 0, combinational from counters:
  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, for whole lines, including all hcnt values.
  - vram_re = active & enable.
- Stage 1 registers: de1=active&enable, hs1, vs1, fs1=(hcnt==0 && vcnt==0 && enable).
- Stage 2 registers, i.e. the outputs:
  - rgb_de, rgb_hsync, rgb_vsync, frame_start take the stage-1 values.
  - rgb_data = de1 ? palette[4*vram_rdata +: 4] : 0.
- enable low: counters reset synchronously to 0. Stage-1 and stage-2 registers load 0 on that same edge, so outputs blank on the first edge enable is sampled low. There is no partial-line completion.
- enable high again: the frame restarts at (0,0) and first output appears 2 edges later. A stale in-flight pixel is never emitted.
- A palette change takes effect on the next stage-2 load. It is not frame-synchronised.
- vram_rdata is ignored unless de1=1.

## Timing
- Reset (async): hcnt=vcnt=0. All stage registers are 0, so rgb_de=rgb_hsync=rgb_vsync=frame_start=0 and rgb_data=0.
- Latency: counter state (h,v) at cycle N appears on outputs after the edge ending cycle N+1, i.e. exactly 2 clocks later. de, sync, data and frame_start are mutually aligned.
- vram_addr is stable for the full cycle in which vram_re is high. The RAM must return data at the next edge.
- Default frame = 180 x 154 = 27720 clocks. frame_start period = V_TOTAL*H_TOTAL clocks while enable stays high.
- Simultaneous H and V wrap (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1): both counters go to 0 on the same edge.
- rst asserted mid-frame: outputs drop to 0 immediately, without waiting for a clock edge.

## Test plan
- Reset/idle: rst pulse, then enable=0 for 100 clocks -> all outputs 0, vram_addr=0x0000, vram_re=0.
- First line:
  - Stimulus: RAM model returns x[1:0] as the pixel; palette=16'hF850; enable rises at edge E0.
  - Required: frame_start and rgb_de rise at E1+1; rgb_data sequence 0,5,8,F repeating for 160 clocks; rgb_de low for 20 clocks.
- Horizontal sync: defaults -> rgb_hsync high for exactly 4 clocks, beginning 8 clocks after rgb_de falls; line period 180.
- Vertical sync and wrap:
  - Required: rgb_vsync high for 2x180 clocks, beginning 2 lines after the last active line; next frame_start exactly 27720 clocks after the first.
  - vram_addr returns to 0x0000 at wrap.
- enable dropped mid-line at hcnt=50, vcnt=3:
  - Required: outputs 0 on the next edge.
  - Re-enable: frame_start 2 edges later with vram_addr restarting at 0x0000.
- Palette change mid-line, palette 16'hF850 -> 16'h0000 at hcnt=80: rgb_data for pixels >=79 (as output) becomes 0 on the next output edge, with no glitch on rgb_de.
